// File: rtl/timer_bank.sv
// timer_bank: a bank of independent timer channels. Each channel counts up
// to its limit and then expires. Periodic channels restart, one-shot channels
// stop, and square-wave channels toggle clk_out on every expiry. Expiries set
// sticky status bits. The masked status bits are OR-ed into one registered
// interrupt line.
module timer_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic                i_cfg_we,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [WIDTH-1:0]    i_cfg_limit,
    input  logic [1:0]          i_cfg_mode,
    input  logic                i_cfg_run,
    input  logic [CHANNELS-1:0] i_irq_mask,
    input  logic [CHANNELS-1:0] i_irq_clr,
    output logic [CHANNELS-1:0] o_tick,
    output logic [CHANNELS-1:0] o_clk_out,
    output logic [CHANNELS-1:0] o_irq_status,
    output logic                o_irq,
    output logic [WIDTH-1:0]    o_rd_count,
    output logic [CHANNELS-1:0] o_running
);

    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_SQUARE  = 2'b10;

    logic [CHANNELS-1:0][WIDTH-1:0] w_count;
    logic [WIDTH-1:0]               w_rd_sel;
    logic                           r_irq;
    logic [WIDTH-1:0]               r_rd_count;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] r_count;
            logic [WIDTH-1:0] r_limit;
            logic [1:0]       r_mode;
            logic             r_run;
            logic             r_clk_out;
            logic             r_tick;
            logic             r_status;
            logic             w_wr;
            logic             w_active;
            logic             w_expire;

            // Out-of-range channel numbers have no matching gi, so those writes are dropped.
            assign w_wr     = i_cfg_we && (i_cfg_ch == CH_W'(gi));
            // A config write to this channel pre-empts counting and any expiry in that cycle.
            assign w_active = i_en && r_run && !w_wr;
            assign w_expire = w_active && (r_count == r_limit);

            // Per-channel counter, configuration, square-wave output and sticky status.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count   <= '0;
                    r_limit   <= '1;
                    r_mode    <= 2'b00;
                    r_run     <= 1'b0;
                    r_clk_out <= 1'b0;
                    r_tick    <= 1'b0;
                    r_status  <= 1'b0;
                end else begin
                    r_tick   <= w_expire;
                    // A new expiry wins over a simultaneous clear.
                    r_status <= w_expire | (r_status & ~i_irq_clr[gi]);
                    if (w_wr) begin
                        r_limit   <= i_cfg_limit;
                        r_mode    <= i_cfg_mode;
                        r_run     <= i_cfg_run;
                        r_count   <= '0;
                        r_clk_out <= 1'b0;
                    end else if (w_active) begin
                        if (w_expire) begin
                            r_count <= '0;
                            if (r_mode == MODE_ONESHOT) begin
                                r_run <= 1'b0;
                            end
                            if (r_mode == MODE_SQUARE) begin
                                r_clk_out <= ~r_clk_out;
                            end
                        end else begin
                            r_count <= r_count + WIDTH'(1);
                        end
                    end
                end
            end

            assign w_count[gi]      = r_count;
            assign o_tick[gi]       = r_tick;
            assign o_clk_out[gi]    = r_clk_out;
            assign o_irq_status[gi] = r_status;
            assign o_running[gi]    = r_run;
        end
    endgenerate

    // Read-back mux; a channel number with no channel behind it reads as zero.
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_cfg_ch == CH_W'(i)) begin
                w_rd_sel = w_count[i];
            end
        end
    end

    // Registered interrupt line and count read-back, one cycle behind their sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq      <= 1'b0;
            r_rd_count <= '0;
        end else begin
            r_irq      <= |(o_irq_status & i_irq_mask);
            r_rd_count <= w_rd_sel;
        end
    end

    assign o_irq      = r_irq;
    assign o_rd_count = r_rd_count;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank, using an 8-bit, 3-channel instance. A table
// of single-channel scenarios is followed by hand-written sequences for reset,
// interrupt, enable and collision corner cases.
module tb_timer_bank;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_limit;
    logic [1:0]    cfg_mode;
    logic          cfg_run;
    logic [N-1:0]  irq_mask;
    logic [N-1:0]  irq_clr;
    logic [N-1:0]  tick;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  irq_status;
    logic          irq;
    logic [W-1:0]  rd_count;
    logic [N-1:0]  running;

    int errors = 0;
    int checks = 0;

    timer_bank #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (en),
        .i_cfg_we    (cfg_we),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_limit (cfg_limit),
        .i_cfg_mode  (cfg_mode),
        .i_cfg_run   (cfg_run),
        .i_irq_mask  (irq_mask),
        .i_irq_clr   (irq_clr),
        .o_tick      (tick),
        .o_clk_out   (clk_out),
        .o_irq_status(irq_status),
        .o_irq       (irq),
        .o_rd_count  (rd_count),
        .o_running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int limit;
        int mode;
        int watch;
        int exp_first;
        int exp_ticks;
        int exp_last;
        int exp_run;
        int exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int lim, input int mode, input int run);
        cfg_we    = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_limit = W'(lim);
        cfg_mode  = 2'(mode);
        cfg_run   = 1'(run);
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic clean();
        for (int c = 0; c < N; c++) cfg_write(c, 255, 0, 0);
        en       = 1'b1;
        irq_mask = '0;
        irq_clr  = '1;
        step();
        irq_clr  = '0;
        step();
    endtask

    initial begin
        int first;
        int cnt;
        int last;
        int other;

        vecs[0] = '{0,   9, 0,  30,  10, 3,  30, 1,   9};
        vecs[1] = '{1,   4, 1,  20,   5, 1,   5, 0,   0};
        vecs[2] = '{2,   2, 2,  12,   3, 4,  12, 1,   2};
        vecs[3] = '{0,   0, 0,   8,   1, 8,   8, 1,   0};
        vecs[4] = '{1,   3, 3,   8,   4, 2,   8, 1,   3};
        vecs[5] = '{2, 255, 0, 512, 256, 2, 512, 1, 255};

        rst_n = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0;
        cfg_mode = '0; cfg_run = 1'b0; irq_mask = '0; irq_clr = '0;
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        step();
        check("reset running", int'(running), 0);
        check("reset status", int'(irq_status), 0);
        check("reset rd_count", int'(rd_count), 0);

        // Reset asserted mid-run aborts everything immediately.
        irq_mask = 3'b001;
        cfg_write(2, 0, 2, 1);
        cfg_write(0, 2, 0, 1);
        repeat (5) step();
        check("pre-reset irq", int'(irq), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async reset tick", int'(tick), 0);
        check("async reset clk_out", int'(clk_out), 0);
        check("async reset status", int'(irq_status), 0);
        check("async reset irq", int'(irq), 0);
        check("async reset rd_count", int'(rd_count), 0);
        check("async reset running", int'(running), 0);
        #2 rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin step(); cnt += int'(|tick); end
        check("idle after reset ticks", cnt, 0);

        // Table-driven single-channel scenarios.
        for (int v = 0; v < 6; v++) begin
            clean();
            cfg_write(vecs[v].ch, vecs[v].limit, vecs[v].mode, 1);
            first = 0; cnt = 0; last = 0;
            for (int k = 1; k <= vecs[v].watch; k++) begin
                step();
                if (tick[vecs[v].ch]) begin
                    cnt++;
                    if (first == 0) first = k;
                    last = k;
                end
            end
            check($sformatf("vec%0d first tick", v), first, vecs[v].exp_first);
            check($sformatf("vec%0d tick count", v), cnt, vecs[v].exp_ticks);
            check($sformatf("vec%0d last tick", v), last, vecs[v].exp_last);
            check($sformatf("vec%0d running", v), int'(running[vecs[v].ch]), vecs[v].exp_run);
            check($sformatf("vec%0d status", v), int'(irq_status[vecs[v].ch]), 1);
            check($sformatf("vec%0d rd_count", v), int'(rd_count), vecs[v].exp_rd);
        end

        // Interrupt: rises one cycle after status, drops when masked, status is sticky.
        clean();
        irq_mask = 3'b001;
        cfg_write(0, 9, 0, 1);
        repeat (9) step();
        step();
        check("irq tick k10", int'(tick[0]), 1);
        check("irq status k10", int'(irq_status[0]), 1);
        check("irq low k10", int'(irq), 0);
        step();
        check("irq high k11", int'(irq), 1);
        check("tick low k11", int'(tick[0]), 0);
        irq_mask = 3'b000;
        step();
        check("irq masked", int'(irq), 0);
        check("status kept masked", int'(irq_status[0]), 1);
        irq_clr = 3'b001;
        step();
        irq_clr = 3'b000;
        check("status cleared", int'(irq_status[0]), 0);

        // Global enable low for 7 cycles stretches the period to 17.
        clean();
        cfg_write(0, 9, 0, 1);
        repeat (3) step();
        en = 1'b0;
        cnt = 0;
        repeat (7) begin step(); cnt += int'(tick[0]); end
        check("en low no tick", cnt, 0);
        check("en low count held", int'(rd_count), 3);
        en = 1'b1;
        first = 0;
        for (int k = 11; k <= 20; k++) begin
            step();
            if (tick[0] && first == 0) first = k;
        end
        check("en stretched first tick", first, 17);

        // Config write on the expiry cycle pre-empts the expiry.
        clean();
        cfg_write(0, 9, 0, 1);
        repeat (9) step();
        cfg_write(0, 9, 0, 1);
        check("collision tick", int'(tick[0]), 0);
        check("collision status", int'(irq_status[0]), 0);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (tick[0] && first == 0) first = k;
        end
        check("collision restart tick", first, 10);
        // Clear on an expiry cycle loses to the new expiry.
        repeat (9) step();
        irq_clr = 3'b001;
        step();
        irq_clr = 3'b000;
        check("clr on expiry tick", int'(tick[0]), 1);
        check("clr on expiry status", int'(irq_status[0]), 1);

        // Write to a non-existent channel is ignored and does not disturb ch0.
        clean();
        cfg_write(0, 9, 0, 1);
        repeat (4) step();
        cfg_write(3, 0, 0, 1);
        check("bad ch running", int'(running), 1);
        first = 0; other = 0;
        for (int k = 6; k <= 10; k++) begin
            step();
            if (tick[0] && first == 0) first = k;
            other += int'(|tick[2:1]);
        end
        check("bad ch ch0 tick", first, 10);
        check("bad ch other ticks", other, 0);

        // Square wave on ch2 with limit 2: 3 cycles high, 3 low.
        clean();
        cfg_write(2, 2, 2, 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("square k%0d", k), int'(clk_out[2]), (k / 3) % 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised bank of independent timer channels for the position subsystem. It replaces the separate counter, clock-generator and interruptor instances with one block. Each channel has its own counter, limit and mode: periodic tick, one-shot, or square-wave clock output (frame clock). Per-channel expiry events are latched into sticky status bits, which are masked and combined into one interrupt line for the position controller.

## Interface
Parameters:
- WIDTH, 32, counter and limit width (2..32)
- CHANNELS, 4, number of channels (1..16)
- CH_W, max(1, clog2(CHANNELS)), channel-select width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes all counters and suppresses events
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  CH_W  channel addressed by cfg_we / rd_ch path
- cfg_limit  in  WIDTH  terminal count; channel period is cfg_limit+1 cycles
- cfg_mode  in  2  00 periodic, 01 one-shot, 10 square wave, 11 treated as 00
- cfg_run  in  1  run bit loaded with the configuration
- irq_mask  in  CHANNELS  per-channel interrupt enable
- irq_clr  in  CHANNELS  write-one-to-clear for status bits
- tick  out  CHANNELS  one-cycle expiry pulse per channel
- clk_out  out  CHANNELS  square-wave output per channel (mode 10)
- irq_status  out  CHANNELS  sticky expiry flags
- irq  out  1  registered OR of irq_status & irq_mask
- rd_count  out  WIDTH  current count of channel cfg_ch, one-cycle latency
- running  out  CHANNELS  per-channel run bit

## Operation
- Each channel has state: count[WIDTH], limit[WIDTH], mode[2], run, clk_out.
- Active cycle: en=1, run=1 and no cfg write to this channel.
  - If count != limit, count increments by 1.
  - If count == limit (expiry), count goes to 0, tick pulses next cycle, and irq_status sets.
- Effect of expiry by mode:
  - Periodic: channel keeps running.
  - One-shot: run clears, count holds at 0.
  - Square wave: clk_out toggles, giving output period 2*(limit+1).
- limit=0, periodic: tick is high on every active cycle.
- Config write (cfg_we=1, cfg_ch < CHANNELS):
  - Loads limit, mode and run; clears count and clk_out.
  - Takes priority over an expiry on that channel in the same cycle: no tick, no status set.
  - Writes with cfg_ch >= CHANNELS are ignored.
- en=0: count, clk_out and run hold; tick stays 0; status only changes via irq_clr.
- Status: the set (expiry) wins over irq_clr in the same cycle. irq_clr on bits that are not set has no effect.
- Masking a set status bit drops irq next cycle. The status bit is retained.
- Counter arithmetic is modulo 2^WIDTH. Counting always stops at limit, so wrap never occurs in normal operation.
- rd_count is registered from the count of cfg_ch.

## Timing
- Reset (rst=0, asynchronous) sets:
  - count=0, limit=all-ones, mode=00, run=0.
  - clk_out=0, tick=0, irq_status=0, irq=0, rd_count=0.
- Reset mid-count aborts immediately. After rst deasserts, all channels stay idle until configured.
- Config write at edge N: count=0 after N. The first expiry is at edge N+limit+1, and tick is high for the cycle after that edge.
- tick, irq_status and clk_out all update on the same edge. irq follows one edge later.
- irq_clr at edge N: irq_status clears at N and irq falls at N+1, unless a new expiry occurs at N.
- rd_count: one-cycle latency from cfg_ch.

## Test plan
- Reset: drive rst=0 mid-run with channel 0 counting -> all outputs 0 asynchronously, running=0, rd_count=0.
- Periodic: ch0 limit=9, mode 00, run=1, en=1 -> tick[0] pulses every 10 cycles, first pulse 10 cycles after the write; irq_status[0] set; with irq_mask[0]=1, irq rises one cycle later.
- One-shot and square wave: ch1 limit=4, mode 01 -> exactly one tick[1], then running[1]=0 and count 0. ch2 limit=2, mode 10 -> clk_out[2] period 6 cycles, duty 50%.
- Global enable: en=0 for 7 cycles mid-count on ch0 (limit=9) -> the tick period stretches to 17 cycles, and no tick occurs while en=0.
- Collisions:
  - cfg_we to ch0 on its expiry cycle -> no tick, status unchanged, count restarts at 0.
  - irq_clr[0] on an expiry cycle -> irq_status[0] stays 1.
- Boundaries:
  - limit=0, periodic -> tick continuously high.
  - CHANNELS=3, cfg_ch=3 write -> ignored.
  - WIDTH=8, limit=255 -> period 256, no wrap glitch.
